// File: rtl/alu_ctrl_if.sv
// ID-to-stage and stage-to-EX signal bundle for the ALU-control decode stage.
// master drives the decode inputs and EX-side ready; slave is the stage itself.
interface alu_ctrl_if #(
    parameter int CTRL_W = 4
);
    logic [1:0]        ALUOp;
    logic [6:0]        opcode;
    logic [2:0]        fn3;
    logic [6:0]        fn7;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic [CTRL_W-1:0] ALUControl;
    logic              illegal;
    logic              out_valid;
    logic              out_ready;
    logic              mc_busy;

    modport master (
        output ALUOp, opcode, fn3, fn7,
        output in_valid, flush, out_ready,
        input  in_ready, ALUControl, illegal,
        input  out_valid, mc_busy
    );

    modport slave (
        input  ALUOp, opcode, fn3, fn7,
        input  in_valid, flush, out_ready,
        output in_ready, ALUControl, illegal,
        output out_valid, mc_busy
    );
endinterface

// File: rtl/alu_ctrl_stage.sv
// Registered ALU-control decode between ID and EX, with optional M ops
// padded to a fixed latency behind a valid/ready handshake.
module alu_ctrl_stage #(
    parameter int CTRL_W     = 4,
    parameter bit ENABLE_M   = 1'b1,
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 8
) (
    input logic       clk,
    input logic       rst_n,
    alu_ctrl_if.slave bus
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int MUL_LD  = (MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0;
    localparam int DIV_LD  = (DIV_CYCLES > 1) ? DIV_CYCLES - 2 : 0;

    localparam logic [3:0] C_ADD  = 4'd0;
    localparam logic [3:0] C_SUB  = 4'd1;
    localparam logic [3:0] C_AND  = 4'd2;
    localparam logic [3:0] C_OR   = 4'd3;
    localparam logic [3:0] C_XOR  = 4'd4;
    localparam logic [3:0] C_PASS = 4'd5;
    localparam logic [3:0] C_SLL  = 4'd6;
    localparam logic [3:0] C_SRL  = 4'd7;
    localparam logic [3:0] C_SRA  = 4'd8;
    localparam logic [3:0] C_SLT  = 4'd9;
    localparam logic [3:0] C_SLTU = 4'd10;
    localparam logic [3:0] C_MUL  = 4'd11;
    localparam logic [3:0] C_DIV  = 4'd12;
    localparam logic [3:0] C_DIVU = 4'd13;
    localparam logic [3:0] C_REM  = 4'd14;
    localparam logic [3:0] C_REMU = 4'd15;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FULL,
        S_MC
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CTRL_W-1:0] ctrl_q;
    logic              ill_q;

    logic [3:0]        code, r_code;
    logic              ill, mc, accept;
    logic [CNT_W-1:0]  ld_val;

    logic unused_opcode;
    assign unused_opcode = ^{bus.opcode[6:5], bus.opcode[3:0]};

    // Base integer map shared by R-type fn7=0 and I-arith
    always_comb begin
        r_code = C_ADD;
        unique case (bus.fn3)
            3'b000: r_code = C_ADD;
            3'b001: r_code = C_SLL;
            3'b010: r_code = C_SLT;
            3'b011: r_code = C_SLTU;
            3'b100: r_code = C_XOR;
            3'b101: r_code = C_SRL;
            3'b110: r_code = C_OR;
            3'b111: r_code = C_AND;
            default: r_code = C_ADD;
        endcase
    end

    always_comb begin
        code = C_ADD;
        ill  = 1'b0;
        unique case (1'b1)
            bus.ALUOp == 2'b10: begin
                if (bus.fn7 == 7'b0000001) begin
                    if (ENABLE_M) begin
                        unique case (bus.fn3)
                            3'b000:  code = C_MUL;
                            3'b100:  code = C_DIV;
                            3'b101:  code = C_DIVU;
                            3'b110:  code = C_REM;
                            3'b111:  code = C_REMU;
                            default: ill  = 1'b1;
                        endcase
                    end else begin
                        ill = 1'b1;
                    end
                end else if (bus.fn7 == 7'b0000000) begin
                    code = r_code;
                end else if (bus.fn7 == 7'b0100000) begin
                    unique case (bus.fn3)
                        3'b000:  code = C_SUB;
                        3'b101:  code = C_SRA;
                        default: ill  = 1'b1;
                    endcase
                end else begin
                    ill = 1'b1;
                end
            end
            bus.ALUOp == 2'b00: begin
                if (bus.opcode[4]) begin
                    if (bus.fn3 == 3'b101)
                        code = bus.fn7[5] ? C_SRA : C_SRL;
                    else
                        code = r_code;
                end else begin
                    code = C_ADD;
                end
            end
            bus.ALUOp == 2'b01: begin
                unique case (bus.fn3)
                    3'b000, 3'b001: code = C_SUB;
                    3'b100, 3'b101: code = C_SLT;
                    3'b110, 3'b111: code = C_SLTU;
                    default:        ill  = 1'b1;
                endcase
            end
            default: code = C_PASS;
        endcase
        if (ill)
            code = C_ADD;
    end

    always_comb begin
        mc     = 1'b0;
        ld_val = '0;
        if (!ill && code == C_MUL && MUL_CYCLES > 1) begin
            mc     = 1'b1;
            ld_val = CNT_W'(MUL_LD);
        end else if (!ill && code >= C_DIV && DIV_CYCLES > 1) begin
            mc     = 1'b1;
            ld_val = CNT_W'(DIV_LD);
        end
    end

    assign bus.in_ready = rst_n && !bus.flush &&
                          (state_q == S_EMPTY ||
                           (state_q == S_FULL && bus.out_ready));
    assign accept = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.flush) begin
            state_d = S_EMPTY;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_EMPTY, S_FULL: begin
                    if (accept) begin
                        state_d = mc ? S_MC : S_FULL;
                        cnt_d   = mc ? ld_val : '0;
                    end else if (state_q == S_FULL && bus.out_ready) begin
                        state_d = S_EMPTY;
                    end
                end
                S_MC: begin
                    if (cnt_q == '0)
                        state_d = S_FULL;
                    else
                        cnt_d = cnt_q - 1'b1;
                end
                default: begin
                    state_d = S_EMPTY;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            cnt_q   <= '0;
            ctrl_q  <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                ctrl_q <= CTRL_W'(code);
                ill_q  <= ill;
            end
        end
    end

    assign bus.ALUControl = ctrl_q;
    assign bus.illegal    = ill_q;
    assign bus.out_valid  = (state_q == S_FULL);
    assign bus.mc_busy    = (state_q == S_MC);

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed bench for alu_ctrl_stage: decode map, streaming, M latency,
// back-pressure, flush, async reset and the ENABLE_M=0 variant.
module tb_alu_ctrl_stage;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    alu_ctrl_if #(.CTRL_W(4)) bm ();
    alu_ctrl_if #(.CTRL_W(4)) bn ();

    alu_ctrl_stage #(
        .CTRL_W(4), .ENABLE_M(1'b1), .MUL_CYCLES(3), .DIV_CYCLES(8)
    ) u_m (
        .clk(clk), .rst_n(rst_n), .bus(bm)
    );

    alu_ctrl_stage #(
        .CTRL_W(4), .ENABLE_M(1'b0), .MUL_CYCLES(3), .DIV_CYCLES(8)
    ) u_n (
        .clk(clk), .rst_n(rst_n), .bus(bn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [1:0] op, input logic [6:0] opc,
                       input logic [2:0] f3, input logic [6:0] f7,
                       input logic v);
        bm.ALUOp    = op;
        bm.opcode   = opc;
        bm.fn3      = f3;
        bm.fn7      = f7;
        bm.in_valid = v;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        drv(2'b00, 7'd0, 3'd0, 7'd0, 1'b0);
        bm.flush = 1'b0; bm.out_ready = 1'b1;
        bn.ALUOp = 2'b00; bn.opcode = 7'd0; bn.fn3 = 3'd0; bn.fn7 = 7'd0;
        bn.in_valid = 1'b0; bn.flush = 1'b0; bn.out_ready = 1'b1;

        #2;
        chk("rst_out_valid", 32'(bm.out_valid), 32'd0);
        chk("rst_ctrl", 32'(bm.ALUControl), 32'd0);
        chk("rst_illegal", 32'(bm.illegal), 32'd0);
        chk("rst_mc_busy", 32'(bm.mc_busy), 32'd0);
        chk("rst_in_ready", 32'(bm.in_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", 32'(bm.in_ready), 32'd1);

        // R-type sub, then sra
        drv(2'b10, 7'b0110011, 3'b000, 7'b0100000, 1'b1);
        tick();
        chk("sub_valid", 32'(bm.out_valid), 32'd1);
        chk("sub_ctrl", 32'(bm.ALUControl), 32'h1);
        chk("sub_illegal", 32'(bm.illegal), 32'd0);
        drv(2'b10, 7'b0110011, 3'b101, 7'b0100000, 1'b1);
        tick();
        chk("sra_ctrl", 32'(bm.ALUControl), 32'h8);
        chk("sra_valid", 32'(bm.out_valid), 32'd1);

        // streaming add, xor, slti
        drv(2'b10, 7'b0110011, 3'b000, 7'b0000000, 1'b1);
        #1 chk("str_rdy0", 32'(bm.in_ready), 32'd1);
        tick();
        chk("str_add", 32'(bm.ALUControl), 32'h0);
        drv(2'b10, 7'b0110011, 3'b100, 7'b0000000, 1'b1);
        #1 chk("str_rdy1", 32'(bm.in_ready), 32'd1);
        tick();
        chk("str_xor", 32'(bm.ALUControl), 32'h4);
        drv(2'b00, 7'b0010011, 3'b010, 7'b0000000, 1'b1);
        #1 chk("str_rdy2", 32'(bm.in_ready), 32'd1);
        tick();
        chk("str_slti", 32'(bm.ALUControl), 32'h9);
        chk("str_valid", 32'(bm.out_valid), 32'd1);
        bm.in_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(bm.out_valid), 32'd0);

        // MUL, 3-cycle latency
        drv(2'b10, 7'b0110011, 3'b000, 7'b0000001, 1'b1);
        tick();
        bm.in_valid = 1'b0;
        #1;
        chk("mul_busy0", 32'(bm.mc_busy), 32'd1);
        chk("mul_rdy0", 32'(bm.in_ready), 32'd0);
        chk("mul_val0", 32'(bm.out_valid), 32'd0);
        tick();
        chk("mul_busy1", 32'(bm.mc_busy), 32'd1);
        chk("mul_rdy1", 32'(bm.in_ready), 32'd0);
        chk("mul_val1", 32'(bm.out_valid), 32'd0);
        tick();
        chk("mul_busy2", 32'(bm.mc_busy), 32'd0);
        chk("mul_val2", 32'(bm.out_valid), 32'd1);
        chk("mul_ctrl", 32'(bm.ALUControl), 32'hB);

        // back-pressure while FULL
        bm.out_ready = 1'b0;
        drv(2'b10, 7'b0110011, 3'b000, 7'b0000000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1 chk("bp_rdy", 32'(bm.in_ready), 32'd0);
            tick();
            chk("bp_valid", 32'(bm.out_valid), 32'd1);
            chk("bp_ctrl", 32'(bm.ALUControl), 32'hB);
        end
        bm.out_ready = 1'b1;
        bm.in_valid  = 1'b0;
        tick();
        chk("bp_release", 32'(bm.out_valid), 32'd0);

        // flush during DIV wait
        drv(2'b10, 7'b0110011, 3'b100, 7'b0000001, 1'b1);
        tick();
        bm.in_valid = 1'b0;
        #1 chk("div_busy", 32'(bm.mc_busy), 32'd1);
        tick();
        bm.flush = 1'b1;
        bm.in_valid = 1'b1;
        #1 chk("fl_rdy", 32'(bm.in_ready), 32'd0);
        tick();
        bm.flush = 1'b0;
        bm.in_valid = 1'b0;
        #1;
        chk("fl_busy", 32'(bm.mc_busy), 32'd0);
        chk("fl_valid", 32'(bm.out_valid), 32'd0);
        chk("fl_ctrl_held", 32'(bm.ALUControl), 32'hC);
        chk("fl_idle_rdy", 32'(bm.in_ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("fl_never_valid", 32'(bm.out_valid), 32'd0);
        end

        // misc decode: illegal branch, passB, srai, bgeu
        drv(2'b01, 7'b1100011, 3'b010, 7'b0000000, 1'b1);
        tick();
        chk("br_ill", 32'(bm.illegal), 32'd1);
        chk("br_ill_ctrl", 32'(bm.ALUControl), 32'h0);
        chk("br_ill_valid", 32'(bm.out_valid), 32'd1);
        drv(2'b11, 7'b0110111, 3'b000, 7'b0000000, 1'b1);
        tick();
        chk("passb", 32'(bm.ALUControl), 32'h5);
        chk("passb_ill", 32'(bm.illegal), 32'd0);
        drv(2'b00, 7'b0010011, 3'b101, 7'b0100000, 1'b1);
        tick();
        chk("srai", 32'(bm.ALUControl), 32'h8);
        drv(2'b01, 7'b1100011, 3'b111, 7'b0000000, 1'b1);
        tick();
        chk("bgeu", 32'(bm.ALUControl), 32'hA);
        drv(2'b10, 7'b0110011, 3'b000, 7'b0000010, 1'b1);
        tick();
        chk("bad_fn7", 32'(bm.illegal), 32'd1);
        bm.in_valid = 1'b0;
        tick();

        // ENABLE_M=0 instance: div is illegal and single-cycle
        bn.ALUOp = 2'b10; bn.opcode = 7'b0110011;
        bn.fn3 = 3'b100; bn.fn7 = 7'b0000001; bn.in_valid = 1'b1;
        tick();
        bn.in_valid = 1'b0;
        chk("nom_valid", 32'(bn.out_valid), 32'd1);
        chk("nom_ill", 32'(bn.illegal), 32'd1);
        chk("nom_ctrl", 32'(bn.ALUControl), 32'h0);
        chk("nom_busy", 32'(bn.mc_busy), 32'd0);
        tick();

        // async reset mid DIV wait
        drv(2'b10, 7'b0110011, 3'b111, 7'b0000001, 1'b1);
        tick();
        bm.in_valid = 1'b0;
        tick();
        chk("pre_rst_busy", 32'(bm.mc_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bm.mc_busy), 32'd0);
        chk("arst_valid", 32'(bm.out_valid), 32'd0);
        chk("arst_ctrl", 32'(bm.ALUControl), 32'd0);
        chk("arst_ill", 32'(bm.illegal), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", 32'(bm.out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
